// File: rtl/input_port_vc_buffer_pkg.sv
`default_nettype none
// ============================================================================
// input_port_vc_buffer_pkg : shared sizing constants for the VC input buffer
// Rev 1.0
// ============================================================================
package input_port_vc_buffer_pkg;

  localparam int c_DATA_W     = 5;
  localparam int c_DEPTH      = 4;
  localparam int c_AF_THRESH  = 3;
  localparam int c_VC_SEL_BIT = c_DATA_W;

endpackage
`default_nettype wire

// File: rtl/input_port_vc_buffer_fifo_vc.sv
`default_nettype none
// ============================================================================
// fifo_vc : DEPTH x DATA_W first-word-fall-through FIFO with flags and
//           overflow/underflow pulses. Rev 1.0
// ============================================================================
module fifo_vc #(
  parameter int DATA_W    = 5,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_afull,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] c_AF_CNT    = CW'(AF_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_DEPTH_CNT);
  assign o_afull = (r_count >= c_AF_CNT);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop_ok    = i_pop && !o_empty;
  assign w_push_ok   = i_push && (!o_full || i_pop);
  assign o_overflow  = i_push && o_full && !i_pop;
  assign o_underflow = i_pop && o_empty;

  assign o_data = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_port_vc_buffer.sv
`default_nettype none
// ============================================================================
// input_port_vc_buffer : two-VC router input buffer (demux, pause, sticky err)
// Rev 1.0
// ============================================================================
module input_port_vc_buffer
  import input_port_vc_buffer_pkg::*;
#(
  parameter int DATA_W    = c_DATA_W,
  parameter int DEPTH     = c_DEPTH,
  parameter int AF_THRESH = c_AF_THRESH
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W:0]   data_in,
  input  logic              valid_in,
  input  logic              popVC0,
  input  logic              popVC1,
  output logic [DATA_W-1:0] VC0_out,
  output logic [DATA_W-1:0] VC1_out,
  output logic              validVC0,
  output logic              validVC1,
  output logic              emptyVC0,
  output logic              emptyVC1,
  output logic              fullVC0,
  output logic              fullVC1,
  output logic              almost_fullVC0,
  output logic              almost_fullVC1,
  output logic              pause,
  output logic              error_out
);

  logic w_sel;
  logic w_push0, w_push1;
  logic w_ovf0, w_ovf1, w_unf0, w_unf1;
  logic r_error;

  assign w_sel   = data_in[DATA_W];
  assign w_push0 = valid_in && !w_sel;
  assign w_push1 = valid_in && w_sel;

  fifo_vc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_vc0 (
    .clk         (clk),
    .rst_n       (reset_L),
    .i_push      (w_push0),
    .i_pop       (popVC0),
    .i_data      (data_in[DATA_W-1:0]),
    .o_data      (VC0_out),
    .o_empty     (emptyVC0),
    .o_full      (fullVC0),
    .o_afull     (almost_fullVC0),
    .o_overflow  (w_ovf0),
    .o_underflow (w_unf0)
  );

  fifo_vc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_vc1 (
    .clk         (clk),
    .rst_n       (reset_L),
    .i_push      (w_push1),
    .i_pop       (popVC1),
    .i_data      (data_in[DATA_W-1:0]),
    .o_data      (VC1_out),
    .o_empty     (emptyVC1),
    .o_full      (fullVC1),
    .o_afull     (almost_fullVC1),
    .o_overflow  (w_ovf1),
    .o_underflow (w_unf1)
  );

  assign validVC0  = !emptyVC0;
  assign validVC1  = !emptyVC1;
  assign pause     = almost_fullVC0 | almost_fullVC1;
  assign error_out = r_error;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_error <= 1'b0;
    end else if (w_ovf0 || w_ovf1 || w_unf0 || w_unf1) begin
      r_error <= 1'b1;
    end
  end

endmodule
`default_nettype wire
